// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
//==============================================================================
// Module   : aes_ctrl_pkg
// Brief    : Shared types and widths for the AES job scheduler.
// Revision : 1.0 - initial release
//==============================================================================
package aes_ctrl_pkg;

    localparam int AES_BLK_W = 128;
    localparam int REQ_ID_W  = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage : aes_ctrl_pkg
`default_nettype wire

// File: rtl/aes_rr_arb2.sv
`default_nettype none
//==============================================================================
// Module   : aes_rr_arb2
// Brief    : Two-way round-robin arbiter; on a tie the port that was not
//            granted last time wins.
// Revision : 1.0 - initial release
//==============================================================================
module aes_rr_arb2
    import aes_ctrl_pkg::*;
(
    input  logic [1:0]          valid,
    input  logic                last_grant,
    input  logic                enable,
    output logic [REQ_ID_W-1:0] grant,
    output logic                grant_valid
);

    // Tie goes to the other port; a lone request simply wins.
    always_comb begin
        grant       = valid[1];
        grant_valid = enable & (|valid);
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end
    end

endmodule : aes_rr_arb2
`default_nettype wire

// File: rtl/aes_job_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : aes_job_scheduler
// Brief    : Shares one AES core between two requesters; launches one job at
//            a time, guards it with a timeout and returns a tagged response.
// Revision : 1.0 - initial release
//==============================================================================
module aes_job_scheduler
    import aes_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                 AES_clk,
    input  logic                 AES_rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AES_BLK_W-1:0] req0_data,
    input  logic [AES_BLK_W-1:0] req0_key,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AES_BLK_W-1:0] req1_data,
    input  logic [AES_BLK_W-1:0] req1_key,
    output logic                 core_en,
    output logic [AES_BLK_W-1:0] core_data,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic                 core_out_valid,
    input  logic [AES_BLK_W-1:0] core_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [AES_BLK_W-1:0] rsp_data,
    output logic [REQ_ID_W-1:0]  rsp_id,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [15:0]          job_count
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_grant;
    logic [CNT_W-1:0]      r_cnt;
    logic [AES_BLK_W-1:0]  r_core_data;
    logic [AES_BLK_W-1:0]  r_core_key;
    logic [AES_BLK_W-1:0]  r_rsp_data;
    logic [REQ_ID_W-1:0]   r_rsp_id;
    logic                  r_rsp_err;
    logic [15:0]           r_job_count;

    logic [REQ_ID_W-1:0]   w_grant;
    logic                  w_grant_valid;
    logic                  w_timeout;

    aes_rr_arb2 u_arb (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (r_last_grant),
        .enable      (r_state == IDLE),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    // Arbiter only grants a requester that is valid, so a grant is an acceptance.
    assign req0_ready = w_grant_valid & (w_grant == 1'b0);
    assign req1_ready = w_grant_valid & (w_grant == 1'b1);
    assign w_timeout  = (r_cnt == c_cnt_last);

    // Decoded from state so an async reset drops the core enable immediately.
    assign core_en    = (r_state == LAUNCH) || (r_state == WAIT);
    assign rsp_valid  = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign core_data  = r_core_data;
    assign core_key   = r_core_key;
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_rsp_id;
    assign rsp_err    = r_rsp_err;
    assign job_count  = r_job_count;

    // State register.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a core result beats a timeout in the same WAIT cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_next = LAUNCH;
            LAUNCH:  w_state_next = WAIT;
            WAIT:    if (core_out_valid || w_timeout) w_state_next = RESP;
            RESP:    if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Job datapath: latch the winning request, time the core, capture the result.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_core_data  <= '0;
            r_core_key   <= '0;
            r_rsp_data   <= '0;
            r_rsp_id     <= '0;
            r_rsp_err    <= 1'b0;
            r_job_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_core_data  <= w_grant ? req1_data : req0_data;
                        r_core_key   <= w_grant ? req1_key  : req0_key;
                        r_rsp_id     <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                // core_out_valid may still be high from the previous job here.
                LAUNCH: r_cnt <= '0;
                WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (core_out_valid) begin
                        r_rsp_data <= core_out;
                        r_rsp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_job_count <= r_job_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : aes_job_scheduler
`default_nettype wire

// File: tb/tb_aes_job_scheduler.sv
`default_nettype none
//==============================================================================
// Module   : tb_aes_job_scheduler
// Brief    : Directed self-checking bench for aes_job_scheduler.
// Revision : 1.0 - initial release
//==============================================================================
module tb_aes_job_scheduler;

    localparam int TO = 16;

    logic         AES_clk = 1'b0;
    logic         AES_rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_data, req0_key, req1_data, req1_key;
    logic         core_en;
    logic [127:0] core_data, core_key;
    logic         core_out_valid;
    logic [127:0] core_out;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_data;
    logic [0:0]   rsp_id;
    logic         rsp_err, busy;
    logic [15:0]  job_count;

    int checks = 0;
    int passes = 0;

    aes_job_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
        .AES_clk        (AES_clk),
        .AES_rst        (AES_rst),
        .req0_valid     (req0_valid),
        .req0_ready     (req0_ready),
        .req0_data      (req0_data),
        .req0_key       (req0_key),
        .req1_valid     (req1_valid),
        .req1_ready     (req1_ready),
        .req1_data      (req1_data),
        .req1_key       (req1_key),
        .core_en        (core_en),
        .core_data      (core_data),
        .core_key       (core_key),
        .core_out_valid (core_out_valid),
        .core_out       (core_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_id         (rsp_id),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .job_count      (job_count)
    );

    always #5 AES_clk = ~AES_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Stimulus helpers (no checking inside).
    task automatic do_reset();
        @(negedge AES_clk);
        AES_rst = 1'b1;
        repeat (2) @(negedge AES_clk);
        AES_rst = 1'b0;
    endtask

    // Raise a request and return at the LAUNCH negedge once accepted.
    task automatic request(input bit id, input logic [127:0] d, input logic [127:0] k,
                           output bit ok);
        ok = 1'b0;
        if (id == 1'b0) begin req0_valid = 1'b1; req0_data = d; req0_key = k; end
        else            begin req1_valid = 1'b1; req1_data = d; req1_key = k; end
        for (int c = 0; c < 50; c++) begin
            #1;
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                ok = 1'b1;
                break;
            end
            @(negedge AES_clk);
        end
        if (ok) @(negedge AES_clk);
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Called at the LAUNCH negedge; pulses the result lat cycles later and
    // returns at the negedge where the response should be visible.
    task automatic drive_core(input int lat, input logic [127:0] res);
        repeat (lat) @(negedge AES_clk);
        core_out_valid = 1'b1;
        core_out       = res;
        @(negedge AES_clk);
        core_out_valid = 1'b0;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(negedge AES_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({core_en, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {core_en, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready});
        else passes++;
        checks++;
        if ({core_data, core_key, rsp_data, job_count} !== '0)
            $display("FAIL reset_data: core_data %h core_key %h rsp_data %h job_count %h expected all 0",
                     core_data, core_key, rsp_data, job_count);
        else passes++;
    endtask

    task automatic test_single();
        bit ok;
        bit bad;
        logic [127:0] k  = 128'h000102030405060708090a0b0c0d0e0f;
        logic [127:0] p  = 128'h00112233445566778899aabbccddeeff;
        logic [127:0] ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        request(1'b0, p, k, ok);
        checks++;
        if (!ok) $display("FAIL single_accept: got no ready expected ready within 50 cycles");
        else passes++;
        checks++;
        if ({core_en, busy, core_data, core_key} !== {1'b1, 1'b1, p, k})
            $display("FAIL single_launch: core_en %b data %h key %h expected 1 %h %h",
                     core_en, core_data, core_key, p, k);
        else passes++;
        // Result arrives 11 cycles after the enable rises; nothing before.
        bad = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (i > 0 && (rsp_valid !== 1'b0 || core_en !== 1'b1)) bad = 1'b1;
            if (i == 10) begin core_out_valid = 1'b1; core_out = ct; end
            @(negedge AES_clk);
        end
        core_out_valid = 1'b0;
        checks++;
        if (bad) $display("FAIL single_wait: got early response expected rsp_valid=0 core_en=1 in WAIT");
        else passes++;
        checks++;
        if ({rsp_valid, rsp_id, rsp_err, core_en, rsp_data} !== {4'b1000, ct})
            $display("FAIL single_rsp: valid/id/err/en %b data %h expected 1000 %h",
                     {rsp_valid, rsp_id, rsp_err, core_en}, rsp_data, ct);
        else passes++;
        handshake();
        checks++;
        if ({rsp_valid, busy, job_count} !== {2'b00, 16'd1})
            $display("FAIL single_done: valid %b busy %b count %0d expected 0 0 1",
                     rsp_valid, busy, job_count);
        else passes++;
    endtask

    task automatic test_timeout();
        bit ok;
        bit bad;
        request(1'b1, 128'h1111, 128'h2222, ok);
        checks++;
        if (!ok) $display("FAIL timeout_accept: got no ready expected ready");
        else passes++;
        bad = 1'b0;
        for (int i = 0; i < TO; i++) begin
            @(negedge AES_clk);
            if (core_en !== 1'b1 || rsp_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) $display("FAIL timeout_wait: got early exit expected %0d WAIT cycles", TO);
        else passes++;
        @(negedge AES_clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_id, core_en, rsp_data} !== {4'b1110, 128'h0})
            $display("FAIL timeout_rsp: valid/err/id/en %b data %h expected 1110 0",
                     {rsp_valid, rsp_err, rsp_id, core_en}, rsp_data);
        else passes++;
        handshake();
        checks++;
        if (job_count !== 16'd2)
            $display("FAIL timeout_count: got %0d expected 2", job_count);
        else passes++;
    endtask

    task automatic test_contention();
        bit got;
        bit g;
        int n0;
        int n1;
        logic [127:0] res;
        do_reset();
        n0 = 0; n1 = 0;
        req0_data = 128'hA0; req0_key = 128'hA1;
        req1_data = 128'hB0; req1_key = 128'hB1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                #1;
                if (req0_ready || req1_ready) got = 1'b1;
                else @(negedge AES_clk);
            end
            checks++;
            if (!got) $display("FAIL cont_ready_%0d: got no ready expected a grant", j);
            else passes++;
            g = req1_ready;
            checks++;
            if (g !== 1'(j % 2)) $display("FAIL cont_grant_%0d: got %0d expected %0d", j, g, j % 2);
            else passes++;
            @(negedge AES_clk);
            if (g) begin n1++; if (n1 == 3) req1_valid = 1'b0; end
            else   begin n0++; if (n0 == 3) req0_valid = 1'b0; end
            res = 128'hC0FFEE00 + 128'(j);
            drive_core(2, res);
            checks++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'(j % 2), res})
                $display("FAIL cont_rsp_%0d: valid %b id %0d data %h expected 1 %0d %h",
                         j, rsp_valid, rsp_id, rsp_data, j % 2, res);
            else passes++;
            handshake();
        end
        checks++;
        if (job_count !== 16'd6) $display("FAIL cont_count: got %0d expected 6", job_count);
        else passes++;
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit bad;
        logic [127:0] r1 = 128'hDEADBEEF_00000001;
        logic [127:0] r2 = 128'hDEADBEEF_00000002;
        request(1'b0, 128'h55, 128'h66, ok);
        drive_core(4, r1);
        req1_valid = 1'b1; req1_data = 128'h77; req1_key = 128'h88;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if ({rsp_valid, rsp_id, rsp_data, req1_ready} !== {2'b10, r1, 1'b0}) bad = 1'b1;
            @(negedge AES_clk);
        end
        checks++;
        if (!ok || bad) $display("FAIL bp_hold: got ok=%b unstable=%b expected ok=1 unstable=0", ok, bad);
        else passes++;
        handshake();
        #1;
        checks++;
        if ({rsp_valid, req1_ready} !== 2'b01)
            $display("FAIL bp_turnaround: valid/ready1 %b expected 01", {rsp_valid, req1_ready});
        else passes++;
        @(negedge AES_clk);
        req1_valid = 1'b0;
        checks++;
        if ({core_en, core_data, core_key} !== {1'b1, 128'h77, 128'h88})
            $display("FAIL bp_launch: en %b data %h key %h expected 1 77 88", core_en, core_data, core_key);
        else passes++;
        drive_core(1, r2);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {2'b11, r2})
            $display("FAIL bp_rsp: valid %b id %0d data %h expected 1 1 %h", rsp_valid, rsp_id, rsp_data, r2);
        else passes++;
        handshake();
    endtask

    task automatic test_stale();
        bit ok;
        logic [127:0] rv = 128'h0123456789ABCDEF;
        request(1'b0, 128'h99, 128'hAA, ok);
        core_out_valid = 1'b1; core_out = 128'hBAD;
        @(negedge AES_clk);
        core_out_valid = 1'b0;
        checks++;
        if ({ok, rsp_valid, core_en} !== 3'b101)
            $display("FAIL stale_launch: ok/valid/en %b expected 101", {ok, rsp_valid, core_en});
        else passes++;
        repeat (TO - 1) @(negedge AES_clk);
        core_out_valid = 1'b1; core_out = rv;
        @(negedge AES_clk);
        core_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, rv})
            $display("FAIL coincident: valid/err %b data %h expected 10 %h", {rsp_valid, rsp_err}, rsp_data, rv);
        else passes++;
        core_out_valid = 1'b1; core_out = 128'hBAD2;
        @(negedge AES_clk);
        core_out_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, rv})
            $display("FAIL resp_ignore: valid %b data %h expected 1 %h", rsp_valid, rsp_data, rv);
        else passes++;
        handshake();
    endtask

    task automatic test_mid_reset();
        bit ok;
        request(1'b0, 128'h31, 128'h32, ok);
        repeat (3) @(negedge AES_clk);
        AES_rst = 1'b1;
        #1;
        checks++;
        if ({ok, core_en, rsp_valid, busy, job_count} !== {4'b1000, 16'd0})
            $display("FAIL midrst: ok/en/valid/busy %b count %0d expected 1000 0",
                     {ok, core_en, rsp_valid, busy}, job_count);
        else passes++;
        @(negedge AES_clk);
        AES_rst = 1'b0;
        request(1'b0, 128'h41, 128'h42, ok);
        drive_core(3, 128'hFACE);
        checks++;
        if ({ok, rsp_valid, rsp_id, rsp_err, rsp_data} !== {4'b1100, 128'hFACE})
            $display("FAIL midrst_next: ok/valid/id/err %b data %h expected 1100 face",
                     {ok, rsp_valid, rsp_id, rsp_err}, rsp_data);
        else passes++;
        handshake();
        checks++;
        if (job_count !== 16'd1) $display("FAIL midrst_count: got %0d expected 1", job_count);
        else passes++;
    endtask

    initial begin
        AES_rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
        core_out_valid = 1'b0; core_out = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_timeout();
        test_contention();
        test_back_to_back();
        test_stale();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_aes_job_scheduler
`default_nettype wire

// File: doc/aes_job_scheduler.md
Name: aes_job_scheduler

Overview:
- Sits in front of the AES core and shares it between two requester ports.
- Arbitrates between the ports round-robin and launches one encryption job at a time on the core.
- Holds the core enable, data and key stable until the core signals completion, with a timeout.
- Returns the result to the winning requester over a valid/ready response channel tagged with the requester id.

Parameters:
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a job is aborted with an error. Minimum value is 2.
- CNT_W, $clog2(TIMEOUT_CYCLES)+1: width of the timeout counter.

Ports:
- AES_clk  in  1  single clock; all logic is on the rising edge.
- AES_rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_data  in  128  requester 0 plaintext.
- req0_key  in  128  requester 0 key.
- req1_valid  in  1  requester 1 has a job.
- req1_ready  out  1  requester 1 job accepted this cycle.
- req1_data  in  128  requester 1 plaintext.
- req1_key  in  128  requester 1 key.
- core_en  out  1  drives the AES core enable.
- core_data  out  128  drives the AES core data input.
- core_key  out  128  drives the AES core key input.
- core_out_valid  in  1  AES core result valid.
- core_out  in  128  AES core result.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  128  ciphertext, or 0 on timeout.
- rsp_id  out  1  id of the requester that owns the response.
- rsp_err  out  1  1 = job timed out.
- busy  out  1  high whenever state is not IDLE.
- job_count  out  16  completed responses; wraps 0xFFFF→0.

Behaviour:
- Reset (async, any state): state=IDLE; last_grant=1, so req0 wins the first tie; core_en=0; core_data=0; core_key=0; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_err=0; job_count=0; timeout counter=0.
- reqN_ready is combinational: it is high only in IDLE when N is granted. Request acceptance is the cycle where reqN_valid and reqN_ready are both high.
- Arbitration in IDLE:
  - Only one valid request: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - Neither valid: remain in IDLE.
- IDLE→LAUNCH on acceptance:
  - Latch the granted data and key into core_data and core_key.
  - Latch rsp_id = grant.
  - Set last_grant = grant.
- LAUNCH (1 cycle):
  - core_en=1; counter cleared.
  - core_out_valid is ignored here, because it is stale from the previous job.
  - Go to WAIT.
- WAIT:
  - core_en=1; core_data and core_key are held; counter increments each cycle.
  - If core_out_valid=1: capture core_out into rsp_data, set rsp_err=0, go to RESP. This takes priority over a timeout in the same cycle.
  - Else if counter == TIMEOUT_CYCLES-1: set rsp_data=0, rsp_err=1, go to RESP.
- RESP:
  - core_en=0; rsp_valid=1.
  - rsp_data, rsp_id and rsp_err stay stable until the handshake.
  - On rsp_ready: rsp_valid falls next cycle, job_count increments, go to IDLE.
  - core_out_valid is ignored.
- Latency:
  - Accept at cycle T → core_en rises at T+1.
  - core_out_valid seen at cycle W → rsp_valid high at W+1.
  - Minimum turnaround to the next acceptance is one cycle after the response handshake.
- core_en always has at least one low cycle (RESP/IDLE) between jobs, so the core sees a fresh enable edge.
- Requests asserted outside IDLE are not accepted; requesters must hold valid, data and key until ready.
- Asserting AES_rst mid-job aborts it: core_en drops asynchronously and no response is produced.

Decomposition:
- Shared package aes_ctrl_pkg holds:
  - state enum: IDLE, LAUNCH, WAIT, RESP.
  - AES_BLK_W=128.
  - REQ_ID_W=1.
- One sub-module, aes_rr_arb2: a 2-way round-robin arbiter with inputs valid[1:0], last_grant and enable, and outputs grant and grant_valid.
- The FSM, counter and registers stay in aes_job_scheduler.

Test Plan:
- Single request, FIPS-197 vector:
  - req0: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff.
  - Core model returns 69c4e0d86a7b0430d8cdb78070b4c55a after 11 cycles.
  - Required: rsp_valid at W+1 with rsp_id=0, rsp_err=0, that data; job_count=1.
- Contention: req0 and req1 valid together from reset, each held for 3 jobs.
  - Required grant order 0,1,0,1,0,1; six responses with the correct rsp_id.
- Timeout: the core never asserts valid.
  - Required: rsp_err=1 and rsp_data=0 exactly TIMEOUT_CYCLES WAIT cycles after LAUNCH; core_en falls in RESP.
- Backpressure: rsp_ready held low for 20 cycles.
  - Required: rsp_valid, rsp_data and rsp_id stable; req1 valid is not accepted (req1_ready=0) until the handshake completes.
- Stale and coincident valid:
  - core_out_valid pulsed in the LAUNCH cycle → ignored.
  - core_out_valid on the timeout cycle → rsp_err=0 and data captured.
- Mid-job reset: assert AES_rst during WAIT.
  - Required: core_en, rsp_valid and job_count all 0 immediately; the next req0 after release is served normally.
